// File: rtl/ifetch_stage_pkg.sv
// Shared fetch-stage definitions: field widths, NOP encoding, next-PC select codes
// and the IF/ID register layout.
package ifetch_stage_pkg;

  localparam int          INSTR_W = 32;
  localparam int          IMM_W   = 16;
  localparam int          JIDX_W  = 26;
  localparam logic [31:0] PC_INC  = 32'd4;
  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_SEQ  = 2'd1,
    SEL_BR   = 2'd2,
    SEL_JMP  = 2'd3
  } pc_sel_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
    logic               valid;
  } if_id_t;

  // Word-granular branch offset turned into a sign-extended byte offset.
  function automatic logic [31:0] br_byte_off(input logic [IMM_W-1:0] imm);
    return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// Fetch-stage bus: instruction memory port, decode redirect inputs and IF/ID outputs.
interface ifetch_stage_if;
  import ifetch_stage_pkg::*;

  logic [31:0]        imem_addr;
  logic [INSTR_W-1:0] imem_rd;
  logic               stall;
  logic               br_taken;
  logic [IMM_W-1:0]   br_imm;
  logic [31:0]        br_pc4;
  logic               jmp;
  logic [JIDX_W-1:0]  jmp_index;
  logic [INSTR_W-1:0] if_id_instr;
  logic [31:0]        if_id_pc4;
  logic               if_id_valid;
  logic [31:0]        fetch_count;

  modport master (
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count,
    input  imem_rd, stall, br_taken, br_imm, br_pc4, jmp, jmp_index
  );

  modport slave (
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count,
    output imem_rd, stall, br_taken, br_imm, br_pc4, jmp, jmp_index
  );
endinterface

// File: rtl/ifetch_stage_pc_next_sel.sv
// Combinational next-PC mux: stall > jump > branch > sequential.
module pc_next_sel
  import ifetch_stage_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic              stall,
  input  logic              jmp,
  input  logic              br_taken,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [31:0]       br_pc4,
  input  logic [JIDX_W-1:0] jmp_index,
  output logic [31:0]       pc4,
  output logic [31:0]       pc_next,
  output pc_sel_e           sel
);

  logic [31:0] br_target;
  logic [31:0] jmp_target;

  assign pc4        = pc + PC_INC;
  assign br_target  = br_pc4 + br_byte_off(br_imm);
  assign jmp_target = {br_pc4[31:28], jmp_index, 2'b00};

  always_comb begin
    sel     = SEL_SEQ;
    pc_next = pc4;
    if (stall) begin
      sel     = SEL_HOLD;
      pc_next = pc;
    end else if (jmp) begin
      sel     = SEL_JMP;
      pc_next = jmp_target;
    end else if (br_taken) begin
      sel     = SEL_BR;
      pc_next = br_target;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and committed-fetch counter.
// A redirect squashes the wrong-path word into a NOP bubble.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter logic [31:0]        RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
  input logic            clk,
  input logic            rst,
  ifetch_stage_if.master bus
);

  logic [31:0] pc_q, pc_d, pc4;
  if_id_t      if_id_q, if_id_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  pc_sel_e     sel;

  pc_next_sel u_pc_next_sel (
    .pc        (pc_q),
    .stall     (bus.stall),
    .jmp       (bus.jmp),
    .br_taken  (bus.br_taken),
    .br_imm    (bus.br_imm),
    .br_pc4    (bus.br_pc4),
    .jmp_index (bus.jmp_index),
    .pc4       (pc4),
    .pc_next   (pc_d),
    .sel       (sel)
  );

  always_comb begin
    if_id_d       = if_id_q;
    fetch_count_d = fetch_count_q;
    case (sel)
      SEL_SEQ: begin
        if_id_d       = '{instr: bus.imem_rd, pc4: pc4, valid: 1'b1};
        fetch_count_d = fetch_count_q + 32'd1;
      end
      SEL_BR, SEL_JMP: if_id_d = '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_q       <= '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_instr = if_id_q.instr;
  assign bus.if_id_pc4   = if_id_q.pc4;
  assign bus.if_id_valid = if_id_q.valid;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed scenarios plus randomized redirects/stalls against
// an architectural model of the fetch stage.
module tb_ifetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_stage_if ifc ();

  ifetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign ifc.imem_rd = mem_word(ifc.imem_addr);

  int n_pass = 0;
  int n_chk  = 0;

  // Architectural model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  task automatic m_reset();
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
  endtask

  task automatic m_edge();
    logic [31:0] off;
    if (ifc.stall) return;
    if (ifc.jmp || ifc.br_taken) begin
      off = 32'($signed(ifc.br_imm)) * 32'd4;
      m_pc = ifc.jmp ? {ifc.br_pc4[31:28], ifc.jmp_index, 2'b00} : ifc.br_pc4 + off;
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    end else begin
      m_instr = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic clr_in();
    ifc.stall = 0; ifc.br_taken = 0; ifc.jmp = 0;
    ifc.br_imm = '0; ifc.br_pc4 = '0; ifc.jmp_index = '0;
  endtask

  // Model advance, one rising edge, then settle to the following falling edge.
  task automatic step();
    m_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; clr_in(); m_reset();
    #1;
    n_chk++; if (ifc.imem_addr !== 32'd0) $display("FAIL rst_addr got %h exp 0", ifc.imem_addr); else n_pass++;
    n_chk++; if (ifc.if_id_instr !== 32'd0) $display("FAIL rst_instr got %h exp 0", ifc.if_id_instr); else n_pass++;
    n_chk++; if (ifc.if_id_pc4 !== 32'd0) $display("FAIL rst_pc4 got %h exp 0", ifc.if_id_pc4); else n_pass++;
    n_chk++; if (ifc.if_id_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", ifc.if_id_valid); else n_pass++;
    n_chk++; if (ifc.fetch_count !== 32'd0) $display("FAIL rst_cnt got %0d exp 0", ifc.fetch_count); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    n_chk++; if (ifc.imem_addr !== 32'd0) $display("FAIL seq_addr0 got %h exp 0", ifc.imem_addr); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_chk++; if (ifc.imem_addr !== 32'(4*i)) $display("FAIL seq_addr got %h exp %h", ifc.imem_addr, 32'(4*i)); else n_pass++;
      n_chk++; if (ifc.if_id_pc4 !== 32'(4*i)) $display("FAIL seq_pc4 got %h exp %h", ifc.if_id_pc4, 32'(4*i)); else n_pass++;
      n_chk++; if (ifc.if_id_instr !== mem_word(32'(4*(i-1)))) $display("FAIL seq_instr got %h exp %h", ifc.if_id_instr, mem_word(32'(4*(i-1)))); else n_pass++;
      n_chk++; if (ifc.if_id_valid !== 1'b1) $display("FAIL seq_valid got %b exp 1", ifc.if_id_valid); else n_pass++;
    end
    n_chk++; if (ifc.fetch_count !== 32'd3) $display("FAIL seq_cnt got %0d exp 3", ifc.fetch_count); else n_pass++;
  endtask

  task automatic test_branch();
    ifc.br_taken = 1; ifc.br_pc4 = 32'd144; ifc.br_imm = 16'h0004;
    step(); clr_in();
    n_chk++; if (ifc.imem_addr !== 32'd160) $display("FAIL br_addr got %0d exp 160", ifc.imem_addr); else n_pass++;
    n_chk++; if (ifc.if_id_valid !== 1'b0 || ifc.if_id_instr !== 32'd0) $display("FAIL br_bubble got v=%b i=%h exp v=0 i=0", ifc.if_id_valid, ifc.if_id_instr); else n_pass++;
    n_chk++; if (ifc.fetch_count !== m_cnt) $display("FAIL br_cnt got %0d exp %0d", ifc.fetch_count, m_cnt); else n_pass++;
    step();
    n_chk++; if (ifc.if_id_instr !== mem_word(32'd160) || ifc.if_id_pc4 !== 32'd164 || ifc.if_id_valid !== 1'b1)
      $display("FAIL br_target got i=%h p=%0d v=%b exp i=%h p=164 v=1", ifc.if_id_instr, ifc.if_id_pc4, ifc.if_id_valid, mem_word(32'd160));
    else n_pass++;
  endtask

  task automatic test_jump();
    ifc.jmp = 1; ifc.jmp_index = '0; ifc.br_pc4 = 32'd164;
    step(); clr_in();
    n_chk++; if (ifc.imem_addr !== 32'd0 || ifc.if_id_valid !== 1'b0) $display("FAIL jmp_addr got a=%h v=%b exp a=0 v=0", ifc.imem_addr, ifc.if_id_valid); else n_pass++;
    step();
    n_chk++; if (ifc.if_id_instr !== mem_word(32'd0) || ifc.if_id_pc4 !== 32'd4) $display("FAIL jmp_target got i=%h p=%0d exp i=%h p=4", ifc.if_id_instr, ifc.if_id_pc4, mem_word(32'd0)); else n_pass++;
    ifc.br_taken = 1; ifc.br_pc4 = 32'd20; ifc.br_imm = 16'hFFFB;
    step(); clr_in();
    n_chk++; if (ifc.imem_addr !== 32'd0) $display("FAIL neg_br_addr got %h exp 0", ifc.imem_addr); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] cnt_exp;
    ifc.br_taken = 1; ifc.br_pc4 = 32'd36; ifc.br_imm = 16'h0000;
    step(); clr_in();
    step();
    cnt_exp = m_cnt;
    ifc.stall = 1; ifc.br_taken = 1; ifc.br_pc4 = 32'd0; ifc.br_imm = 16'h0008;
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++; if (ifc.imem_addr !== 32'd40) $display("FAIL stall_addr got %0d exp 40", ifc.imem_addr); else n_pass++;
      n_chk++; if (ifc.if_id_instr !== mem_word(32'd36) || ifc.if_id_pc4 !== 32'd40 || ifc.if_id_valid !== 1'b1)
        $display("FAIL stall_ifid got i=%h p=%0d v=%b exp i=%h p=40 v=1", ifc.if_id_instr, ifc.if_id_pc4, ifc.if_id_valid, mem_word(32'd36));
      else n_pass++;
      n_chk++; if (ifc.fetch_count !== cnt_exp) $display("FAIL stall_cnt got %0d exp %0d", ifc.fetch_count, cnt_exp); else n_pass++;
    end
    clr_in();
    step();
    n_chk++; if (ifc.imem_addr !== 32'd44 || ifc.if_id_instr !== mem_word(32'd40)) $display("FAIL stall_release got a=%0d i=%h exp a=44 i=%h", ifc.imem_addr, ifc.if_id_instr, mem_word(32'd40)); else n_pass++;
  endtask

  task automatic test_priority_wrap();
    ifc.jmp = 1; ifc.br_taken = 1; ifc.br_pc4 = 32'h3000_0010; ifc.jmp_index = 26'h000_0123; ifc.br_imm = 16'h0001;
    step(); clr_in();
    n_chk++; if (ifc.imem_addr !== 32'h3000_048C) $display("FAIL prio_addr got %h exp 3000048c", ifc.imem_addr); else n_pass++;
    ifc.jmp = 1; ifc.br_pc4 = 32'hF000_0000; ifc.jmp_index = 26'h3FF_FFFF;
    step(); clr_in();
    n_chk++; if (ifc.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup got %h exp fffffffc", ifc.imem_addr); else n_pass++;
    step();
    n_chk++; if (ifc.imem_addr !== 32'd0 || ifc.if_id_pc4 !== 32'd0 || ifc.if_id_valid !== 1'b1 || ifc.if_id_instr !== mem_word(32'hFFFF_FFFC))
      $display("FAIL wrap got a=%h p=%h v=%b i=%h exp a=0 p=0 v=1 i=%h", ifc.imem_addr, ifc.if_id_pc4, ifc.if_id_valid, ifc.if_id_instr, mem_word(32'hFFFF_FFFC));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    ifc.br_taken = 1; ifc.br_pc4 = 32'd100; ifc.br_imm = 16'h0000;
    step(); clr_in();
    step();
    #2 rst = 1'b1;
    #1;
    n_chk++; if (ifc.imem_addr !== 32'd0 || ifc.if_id_valid !== 1'b0 || ifc.if_id_pc4 !== 32'd0 || ifc.fetch_count !== 32'd0 || ifc.if_id_instr !== 32'd0)
      $display("FAIL async_rst got a=%h v=%b p=%h c=%0d i=%h exp all 0", ifc.imem_addr, ifc.if_id_valid, ifc.if_id_pc4, ifc.fetch_count, ifc.if_id_instr);
    else n_pass++;
    #1 rst = 1'b0;
    m_reset();
    step();
    n_chk++; if (ifc.imem_addr !== 32'd4 || ifc.if_id_instr !== mem_word(32'd0) || ifc.fetch_count !== 32'd1)
      $display("FAIL async_restart got a=%h i=%h c=%0d exp a=4 i=%h c=1", ifc.imem_addr, ifc.if_id_instr, ifc.fetch_count, mem_word(32'd0));
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ifc.stall     = ($urandom_range(0, 99) < 20);
      ifc.jmp       = ($urandom_range(0, 99) < 10);
      ifc.br_taken  = ($urandom_range(0, 99) < 15);
      ifc.br_pc4    = $urandom;
      ifc.br_imm    = 16'($urandom);
      ifc.jmp_index = 26'($urandom);
      step();
      n_chk++; if (ifc.imem_addr !== m_pc) $display("FAIL rnd_addr[%0d] got %h exp %h", i, ifc.imem_addr, m_pc); else n_pass++;
      n_chk++; if (ifc.if_id_instr !== m_instr) $display("FAIL rnd_instr[%0d] got %h exp %h", i, ifc.if_id_instr, m_instr); else n_pass++;
      n_chk++; if (ifc.if_id_pc4 !== m_pc4) $display("FAIL rnd_pc4[%0d] got %h exp %h", i, ifc.if_id_pc4, m_pc4); else n_pass++;
      n_chk++; if (ifc.if_id_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %b exp %b", i, ifc.if_id_valid, m_valid); else n_pass++;
      n_chk++; if (ifc.fetch_count !== m_cnt) $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, ifc.fetch_count, m_cnt); else n_pass++;
    end
    clr_in();
  endtask

  initial begin
    clr_in();
    m_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_priority_wrap();
    test_async_reset();
    test_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
